// File: rtl/pwm_multi_ctrl.sv
// rtl/pwm_multi_ctrl.sv - multi-channel PWM with a shared prescaled timebase and double-buffered compares
module pwm_multi_ctrl #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int PRE_W  = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        addr,
  input  logic              write_en,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] pwm,
  output logic              wrap
);

  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_TOP   = 4'd1;
  localparam logic [3:0] ADDR_COUNT = 4'(2 + NUM_CH);

  logic              run;
  logic [PRE_W-1:0]  pre;
  logic [NUM_CH-1:0] en_mask;
  logic [NUM_CH-1:0] inv_mask;

  logic [WIDTH-1:0]  top_sh;
  logic [WIDTH-1:0]  top_act;
  logic [WIDTH-1:0]  cmp_sh  [NUM_CH];
  logic [WIDTH-1:0]  cmp_act [NUM_CH];

  logic [PRE_W-1:0]  presc;
  logic [WIDTH-1:0]  count;
  logic              tick;
  logic              unused_data;

  // >= keeps the prescaler from running away if it ever sits above PRE
  assign tick        = (presc >= pre);
  assign unused_data = &{1'b0, data_in};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run      <= 1'b0;
      pre      <= '0;
      en_mask  <= '0;
      inv_mask <= '0;
      top_sh   <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_sh[i] <= '0;
      end
    end else if (write_en) begin
      if (addr == ADDR_CTRL) begin
        run      <= data_in[0];
        pre      <= data_in[PRE_W+3:4];
        en_mask  <= data_in[8 +: NUM_CH];
        inv_mask <= data_in[16 +: NUM_CH];
      end
      if (addr == ADDR_TOP) begin
        top_sh <= data_in[WIDTH-1:0];
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (addr == 4'(2 + i)) begin
          cmp_sh[i] <= data_in[WIDTH-1:0];
        end
      end
    end
  end

  // Active period/compare only reload at a wrap, or continuously while stopped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc   <= '0;
      count   <= '0;
      wrap    <= 1'b0;
      top_act <= '1;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_act[i] <= '0;
      end
    end else if (!run) begin
      presc   <= '0;
      count   <= '0;
      wrap    <= 1'b0;
      top_act <= top_sh;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_act[i] <= cmp_sh[i];
      end
    end else begin
      wrap <= 1'b0;
      if (tick) begin
        presc <= '0;
        if (count >= top_act) begin
          count   <= '0;
          wrap    <= 1'b1;
          top_act <= top_sh;
          for (int i = 0; i < NUM_CH; i++) begin
            cmp_act[i] <= cmp_sh[i];
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end else begin
        presc <= presc + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm[i] <= (run && en_mask[i] && (count < cmp_act[i])) ^ inv_mask[i];
      end
    end
  end

  always_comb begin
    data_out = '0;
    if (addr == ADDR_CTRL) begin
      data_out[0]              = run;
      data_out[PRE_W+3:4]      = pre;
      data_out[8 +: NUM_CH]    = en_mask;
      data_out[16 +: NUM_CH]   = inv_mask;
    end else if (addr == ADDR_TOP) begin
      data_out[WIDTH-1:0] = top_sh;
    end else if (addr == ADDR_COUNT) begin
      data_out[WIDTH-1:0] = count;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr == 4'(2 + i)) begin
        data_out[WIDTH-1:0] = cmp_sh[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_multi_ctrl.sv
// tb/tb_pwm_multi_ctrl.sv - self-checking bench for pwm_multi_ctrl (4 channels, 8-bit, 4-bit prescaler)
module tb_pwm_multi_ctrl;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int PRE_W  = 4;
  localparam logic [3:0] A_COUNT = 4'd6;

  logic              clk = 1'b0;
  logic              rstn;
  logic [3:0]        addr;
  logic              write_en;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic [NUM_CH-1:0] pwm;
  logic              wrap;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: time since the period began, in clk cycles
  bit          m_run;
  int          m_pre;
  logic [3:0]  m_en, m_inv;
  int          m_top_sh, m_top_act;
  int          m_cmp_sh  [NUM_CH];
  int          m_cmp_act [NUM_CH];
  int          m_t;
  logic [3:0]  m_pwm;
  logic        m_wrap;

  int hi_cnt [NUM_CH];
  int wr_cnt;

  typedef struct {
    logic        we;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [14];

  pwm_multi_ctrl #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .write_en(write_en),
    .data_in(data_in), .data_out(data_out), .pwm(pwm), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int m_count();
    return m_t / (m_pre + 1);
  endfunction

  function automatic int m_period();
    return (m_pre + 1) * (m_top_act + 1);
  endfunction

  function automatic bit about_to_wrap();
    return m_run && (m_t == m_period() - 1);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      4'd0: begin
        r[0] = m_run; r[7:4] = 4'(m_pre); r[11:8] = m_en; r[19:16] = m_inv;
      end
      4'd1: r = 32'(m_top_sh);
      4'd2, 4'd3, 4'd4, 4'd5: r = 32'(m_cmp_sh[int'(a) - 2]);
      4'd6: r = 32'(m_count());
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_run = 0; m_pre = 0; m_en = '0; m_inv = '0;
    m_top_sh = 255; m_top_act = 255; m_t = 0; m_pwm = '0; m_wrap = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      m_cmp_sh[i] = 0; m_cmp_act[i] = 0;
    end
  endtask

  task automatic model_edge(input logic we, input logic [3:0] a, input logic [31:0] d);
    for (int i = 0; i < NUM_CH; i++)
      m_pwm[i] = (m_run && m_en[i] && (m_count() < m_cmp_act[i])) ^ m_inv[i];
    if (!m_run) begin
      m_t = 0; m_wrap = 1'b0; m_top_act = m_top_sh;
      for (int i = 0; i < NUM_CH; i++) m_cmp_act[i] = m_cmp_sh[i];
    end else if (m_t == m_period() - 1) begin
      m_t = 0; m_wrap = 1'b1; m_top_act = m_top_sh;
      for (int i = 0; i < NUM_CH; i++) m_cmp_act[i] = m_cmp_sh[i];
    end else begin
      m_t = m_t + 1; m_wrap = 1'b0;
    end
    if (we) begin
      case (a)
        4'd0: begin
          m_run = d[0]; m_pre = int'(d[7:4]); m_en = d[11:8]; m_inv = d[19:16];
        end
        4'd1: m_top_sh = int'(d[7:0]);
        4'd2, 4'd3, 4'd4, 4'd5: m_cmp_sh[int'(a) - 2] = int'(d[7:0]);
        default: ;
      endcase
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    end
  endtask

  task automatic check_out();
    tests++;
    if (pwm !== m_pwm || wrap !== m_wrap) begin
      fails++;
      $display("FAIL outputs @cyc %0d: pwm=%b wrap=%b expected pwm=%b wrap=%b",
               cyc, pwm, wrap, m_pwm, m_wrap);
    end
    check_val($sformatf("read addr %0d", addr), data_out, model_read(addr));
  endtask

  // Called at a negedge: drive, advance the model through the next posedge, check at the next negedge
  task automatic step(input logic we, input logic [3:0] a, input logic [31:0] d);
    write_en = we; addr = a; data_in = d;
    model_edge(we, a, d);
    @(posedge clk);
    #1;
    write_en = 1'b0; data_in = '0;
    @(negedge clk);
    cyc++;
    check_out();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, A_COUNT, 32'h0);
  endtask

  task automatic window(input int n);
    wr_cnt = 0;
    for (int i = 0; i < NUM_CH; i++) hi_cnt[i] = 0;
    for (int k = 0; k < n; k++) begin
      step(1'b0, A_COUNT, 32'h0);
      for (int i = 0; i < NUM_CH; i++) if (pwm[i]) hi_cnt[i]++;
      if (wrap) wr_cnt++;
    end
  endtask

  task automatic run_to_wrap();
    int n;
    n = 0;
    do begin
      step(1'b0, A_COUNT, 32'h0);
      n++;
    end while (wrap !== 1'b1 && n < 200);
    if (wrap !== 1'b1) check_val("wrap timeout", 32'(n), 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] d;
    int r;

    rstn = 1'b0; addr = '0; write_en = 1'b0; data_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_val("reset pwm", 32'(pwm), 32'd0);
    check_val("reset wrap", 32'(wrap), 32'd0);
    rstn = 1'b1;

    vecs[0]  = '{1'b0, 4'd1,  32'h0,         32'h000000FF};
    vecs[1]  = '{1'b0, 4'd0,  32'h0,         32'h00000000};
    vecs[2]  = '{1'b0, 4'd2,  32'h0,         32'h00000000};
    vecs[3]  = '{1'b0, 4'd6,  32'h0,         32'h00000000};
    vecs[4]  = '{1'b1, 4'd1,  32'hFFFFFF0A,  32'h0};
    vecs[5]  = '{1'b0, 4'd1,  32'h0,         32'h0000000A};
    vecs[6]  = '{1'b1, 4'd0,  32'hFFFFFFF0,  32'h0};
    vecs[7]  = '{1'b0, 4'd0,  32'h0,         32'h000F0FF0};
    vecs[8]  = '{1'b1, 4'd3,  32'h12345678,  32'h0};
    vecs[9]  = '{1'b0, 4'd3,  32'h0,         32'h00000078};
    vecs[10] = '{1'b1, 4'd6,  32'h00000055,  32'h0};
    vecs[11] = '{1'b0, 4'd6,  32'h0,         32'h00000000};
    vecs[12] = '{1'b1, 4'd12, 32'h00000077,  32'h0};
    vecs[13] = '{1'b0, 4'd12, 32'h0,         32'h00000000};
    for (int v = 0; v < 14; v++) begin
      step(vecs[v].we, vecs[v].a, vecs[v].d);
      if (!vecs[v].we) check_val($sformatf("vec %0d", v), data_out, vecs[v].exp);
    end
    step(1'b1, 4'd0, 32'h0);
    step(1'b1, 4'd3, 32'h0);

    // Basic duty: 3 of 10 high
    step(1'b1, 4'd1, 32'd9);
    step(1'b1, 4'd2, 32'd3);
    step(1'b1, 4'd0, 32'h00000101);
    idle(2);
    window(30);
    check_val("duty hi0", 32'(hi_cnt[0]), 32'd9);
    check_val("duty hi1", 32'(hi_cnt[1]), 32'd0);
    check_val("duty wraps", 32'(wr_cnt), 32'd3);

    // Prescaler 3: period 40, 12 high
    step(1'b1, 4'd0, 32'h0);
    step(1'b1, 4'd0, 32'h00000131);
    idle(2);
    window(80);
    check_val("pre hi0", 32'(hi_cnt[0]), 32'd24);
    check_val("pre wraps", 32'(wr_cnt), 32'd2);

    // Double buffering
    step(1'b1, 4'd0, 32'h0);
    step(1'b1, 4'd0, 32'h00000101);
    run_to_wrap();
    n = 0;
    while (m_count() != 5 && n < 20) begin idle(1); n++; end
    step(1'b1, 4'd2, 32'd7);
    run_to_wrap();
    window(10);
    check_val("dbuf next period", 32'(hi_cnt[0]), 32'd7);
    n = 0;
    while (!about_to_wrap() && n < 20) begin idle(1); n++; end
    step(1'b1, 4'd2, 32'd3);
    check_val("wrap on write cycle", 32'(wrap), 32'd1);
    window(10);
    check_val("dbuf old value kept", 32'(hi_cnt[0]), 32'd7);
    window(10);
    check_val("dbuf new value", 32'(hi_cnt[0]), 32'd3);

    // Edge compares, invert, disabled+invert
    step(1'b1, 4'd0, 32'h0);
    step(1'b1, 4'd3, 32'd0);
    step(1'b1, 4'd4, 32'd10);
    step(1'b1, 4'd5, 32'd5);
    step(1'b1, 4'd0, 32'h00090701);
    idle(2);
    window(20);
    check_val("inv ch0", 32'(hi_cnt[0]), 32'd14);
    check_val("cmp0 ch1", 32'(hi_cnt[1]), 32'd0);
    check_val("cmp>top ch2", 32'(hi_cnt[2]), 32'd20);
    check_val("dis+inv ch3", 32'(hi_cnt[3]), 32'd20);

    // Async reset between edges
    n = 0;
    while (pwm[0] !== 1'b1 && n < 50) begin idle(1); n++; end
    check_val("pwm0 high before reset", 32'(pwm[0]), 32'd1);
    addr = A_COUNT;
    #2 rstn = 1'b0;
    #1;
    check_val("async pwm", 32'(pwm), 32'd0);
    check_val("async wrap", 32'(wrap), 32'd0);
    check_val("async count", data_out, 32'd0);
    model_reset();
    #1 rstn = 1'b1;
    model_edge(1'b0, A_COUNT, 32'h0);
    @(negedge clk);
    cyc++;
    check_out();
    idle(10);
    step(1'b0, 4'd0, 32'h0);
    check_val("idle ctrl", data_out, 32'd0);

    // Randomized traffic
    step(1'b1, 4'd1, 32'($urandom_range(0, 15)));
    for (int i = 0; i < NUM_CH; i++) step(1'b1, 4'(2 + i), 32'($urandom_range(0, 17)));
    d = $urandom(); d[0] = 1'b1; d[7:4] = 4'($urandom_range(0, 3));
    step(1'b1, 4'd0, d);
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 99);
      d = $urandom();
      if (r < 10) begin
        d[7:0] = 8'($urandom_range(0, 17));
        step(1'b1, 4'(2 + $urandom_range(0, NUM_CH - 1)), d);
      end else if (r < 14) begin
        d[7:0] = 8'($urandom_range(0, 15));
        step(1'b1, 4'd1, d);
      end else if (r < 18) begin
        d[0] = m_run; d[7:4] = 4'(m_pre);
        step(1'b1, 4'd0, d);
      end else if (r < 20) begin
        if (m_run) begin
          d[0] = 1'b0; d[7:4] = 4'(m_pre);
        end else begin
          d[0] = 1'b1; d[7:4] = 4'($urandom_range(0, 3));
        end
        step(1'b1, 4'd0, d);
      end else begin
        step(1'b0, 4'($urandom_range(0, 15)), 32'h0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
